// File: rtl/result_serializer_pkg.sv
// Shared types and constants for the result serializer: FSM state encoding,
// default MISR tap mask, and an elaboration-time log2 helper.
package result_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int          DEFAULT_WIDTH = 31;
   localparam logic [30:0] DEFAULT_POLY  = 31'h4800_0000;  // taps 30 and 27

   // Smallest r with 2**r >= n; used to check that the shift counter is wide enough.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/result_serializer_misr.sv
// Multiple-input signature register: folds one WIDTH-bit result per enabled
// cycle into a Galois-free (external-XOR) LFSR signature.
module misr_reg
   import result_serializer_pkg::*;
#(
   parameter int               WIDTH = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] res,
   output logic [WIDTH-1:0] sig
);

   logic fb;

   assign fb = ^(sig & POLY);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst)
         sig <= '0;
      else if (clr)
         sig <= '0;
      else if (en)
         sig <= {sig[WIDTH-2:0], fb} ^ res;
   end

endmodule

// File: rtl/result_serializer.sv
// Folds compressor results into a MISR and, on request, shifts a snapshot of
// the signature out MSB-first on a single serial pin.
module result_serializer
   import result_serializer_pkg::*;
#(
   parameter int               WIDTH = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
   parameter int               CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] res,
   input  logic             clr,
   input  logic             dump,
   output logic [WIDTH-1:0] sig,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             busy
);

   if (WIDTH < 2 || clog2(WIDTH) > CNT_W) begin : g_bad_cfg
      $error("result_serializer: WIDTH must be >= 2 and fit in CNT_W counter bits");
   end

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shadow_q;
   logic [CNT_W-1:0]   cnt_q;

   misr_reg #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
   ) u_misr (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (en),
      .res (res),
      .sig (sig)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (dump) state_d = SHIFT;
         SHIFT:   if (cnt_q == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sout       = 1'b0;
      sout_valid = 1'b0;
      sout_last  = 1'b0;
      busy       = 1'b0;
      if (state_q == SHIFT) begin
         sout       = shadow_q[WIDTH-1];
         sout_valid = 1'b1;
         sout_last  = (cnt_q == '0);
         busy       = 1'b1;
      end
   end

   // The snapshot takes sig before this edge's clr/en, so the readout never
   // includes the result sampled alongside dump.
   // NOTE: the shadow is a plain datapath register, reset so the debug view
   // and serial path are deterministic after rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (dump) begin
                  shadow_q <= sig;
                  cnt_q    <= CNT_W'(WIDTH - 1);
               end
            end
            SHIFT: begin
               if (cnt_q != '0) begin
                  shadow_q <= shadow_q << 1;
                  cnt_q    <= cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_result_serializer.sv
// Directed, table-driven bench for result_serializer: MISR folding vectors
// plus hand-written readout sequences for the multi-cycle corner cases.
module tb_result_serializer;

   localparam int W = 31;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [W-1:0] res;
   logic         clr;
   logic         dump;
   logic [W-1:0] sig;
   logic         sout;
   logic         sout_valid;
   logic         sout_last;
   logic         busy;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic         en;
      logic         clr;
      logic [W-1:0] res;
      logic [W-1:0] exp_sig;
   } vec_t;

   vec_t vecs[11];

   result_serializer dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .res        (res),
      .clr        (clr),
      .dump       (dump),
      .sig        (sig),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sout_last  (sout_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      check({name, " busy"},       64'(busy),       64'd0);
      check({name, " sout_valid"}, 64'(sout_valid), 64'd0);
      check({name, " sout"},       64'(sout),       64'd0);
      check({name, " sout_last"},  64'(sout_last),  64'd0);
   endtask

   // Full readout of snapshot exp; optionally clr alongside dump, and an
   // extra dump pulse on readout cycle redump_at (1-based, 0 = none).
   task automatic do_readout(input string name, input logic [W-1:0] exp,
                             input bit clr_too, input int redump_at);
      dump = 1'b1;
      clr  = clr_too;
      step();
      dump = 1'b0;
      clr  = 1'b0;
      if (clr_too) check({name, " sig cleared"}, 64'(sig), 64'd0);
      for (int i = 0; i < W; i++) begin
         check($sformatf("%s valid[%0d]", name, i), 64'(sout_valid), 64'd1);
         check($sformatf("%s busy[%0d]", name, i),  64'(busy),       64'd1);
         check($sformatf("%s bit[%0d]", name, i),   64'(sout),       64'(exp[W-1-i]));
         check($sformatf("%s last[%0d]", name, i),  64'(sout_last),  64'(i == W-1));
         dump = (i + 1 == redump_at);
         step();
         dump = 1'b0;
      end
      check_idle({name, " after"});
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 31'h0000_0001, 31'h0000_0001};
      vecs[1]  = '{1'b1, 1'b0, 31'h0000_0002, 31'h0000_0000};
      vecs[2]  = '{1'b0, 1'b0, 31'h7FFF_FFFF, 31'h0000_0000};
      vecs[3]  = '{1'b1, 1'b0, 31'h4000_0000, 31'h4000_0000};
      vecs[4]  = '{1'b1, 1'b0, 31'h0000_0000, 31'h0000_0001};
      vecs[5]  = '{1'b1, 1'b1, 31'h0000_0055, 31'h0000_0000};
      vecs[6]  = '{1'b1, 1'b0, 31'h4800_0000, 31'h4800_0000};
      vecs[7]  = '{1'b1, 1'b0, 31'h0000_0000, 31'h1000_0000};
      vecs[8]  = '{1'b1, 1'b0, 31'h1234_5678, 31'h3234_5678};
      vecs[9]  = '{1'b1, 1'b0, 31'h0000_0000, 31'h6468_ACF0};
      vecs[10] = '{1'b1, 1'b0, 31'h0000_0000, 31'h48D1_59E1};

      rst = 1'b1; en = 1'b0; res = '0; clr = 1'b0; dump = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("reset sig", 64'(sig), 64'd0);
      check_idle("reset");

      // 1: zero results keep a zero signature
      en = 1'b1; res = '0;
      for (int i = 0; i < 10; i++) step();
      check("zero fold sig", 64'(sig), 64'd0);
      check_idle("zero fold");

      // 2: walk a single one up to tap 27, then feedback kicks in
      res = 31'h1;
      step();
      res = '0;
      for (int i = 0; i < 27; i++) step();
      check("walk to tap27", 64'(sig), 64'h0800_0000);
      step();
      check("tap27 feedback", 64'(sig), 64'h1000_0001);
      en = 1'b0;

      // 3: plain readout
      do_readout("readout", 31'h1000_0001, 1'b0, 0);
      check("sig kept", 64'(sig), 64'h1000_0001);

      // 4: dump during SHIFT is ignored
      do_readout("redump", 31'h1000_0001, 1'b0, 5);
      step();
      check_idle("redump settle");

      // 5: clr with dump snapshots the pre-clear value
      do_readout("clr+dump", 31'h1000_0001, 1'b1, 0);

      // MISR fold vectors, starting from sig = 0
      for (int i = 0; i < $size(vecs); i++) begin
         en  = vecs[i].en;
         clr = vecs[i].clr;
         res = vecs[i].res;
         step();
         check($sformatf("vec[%0d] sig", i), 64'(sig), 64'(vecs[i].exp_sig));
      end
      en = 1'b0; clr = 1'b0; res = '0;

      // 6: reset during readout aborts without sout_last
      dump = 1'b1;
      step();
      dump = 1'b0;
      for (int i = 0; i < 11; i++) begin
         check($sformatf("abort last[%0d]", i), 64'(sout_last), 64'd0);
         step();
      end
      check("abort busy before rst", 64'(busy), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort sig", 64'(sig), 64'd0);
      check_idle("abort");
      step();
      check_idle("abort settle");
      do_readout("post-abort", 31'h0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
